// File: rtl/auto_player.sv
// auto_player: self-play agent for the Genius game. Records the colours shown on
// the LEDs and, once the display phase goes quiet, replays them as button presses.
module auto_player #(
    parameter int COLOR_CODEFY_W = 2,
    parameter int ADDR_WIDTH     = 5,
    parameter int MIN_ON_CYCLES  = 4,
    parameter int IDLE_CYCLES    = 64,
    parameter int PRESS_CYCLES   = 8,
    parameter int GAP_CYCLES     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      led_red,
    input  logic                      led_green,
    input  logic                      led_blue,
    input  logic                      led_yellow,
    output logic [COLOR_CODEFY_W-1:0] player_button,
    output logic                      player_press,
    output logic                      busy,
    output logic                      overflow,
    output logic                      fail_seen,
    output logic [ADDR_WIDTH:0]       captured_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int MAX_A = (MIN_ON_CYCLES > IDLE_CYCLES) ? MIN_ON_CYCLES : IDLE_CYCLES;
    localparam int MAX_B = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
    localparam int TW    = $clog2((MAX_A > MAX_B) ? MAX_A : MAX_B) + 1;

    localparam logic [TW-1:0] ON_MAX     = TW'(MIN_ON_CYCLES);
    localparam logic [TW-1:0] IDLE_LAST  = TW'(IDLE_CYCLES - 1);
    localparam logic [TW-1:0] PRESS_LAST = TW'(PRESS_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] FULL       = CW'(DEPTH);

    localparam logic [1:0] S_LISTEN = 2'd0;
    localparam logic [1:0] S_PRESS  = 2'd1;
    localparam logic [1:0] S_GAP    = 2'd2;

    logic [COLOR_CODEFY_W-1:0] mem_q [DEPTH];

    logic [1:0]                state_q, state_d;
    logic [ADDR_WIDTH-1:0]     wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d, rdNext;
    logic [CW-1:0]             count_q, count_d;
    logic [TW-1:0]             onCnt_q, onCnt_d, idleCnt_q, idleCnt_d, tmr_q, tmr_d;
    logic [COLOR_CODEFY_W-1:0] color_q, color_d, button_q, button_d, ledColor;
    logic                      armed_q, armed_d, press_q, press_d;
    logic                      ovf_q, ovf_d, fail_q, fail_d;
    logic                      memWe, continuing, failEvt;
    logic                      ledNone, ledMulti, ledSingle;
    logic [3:0]                leds;

    assign leds      = {led_yellow, led_blue, led_green, led_red};
    assign ledNone   = (leds == 4'd0);
    assign ledMulti  = ((leds & (leds - 4'd1)) != 4'd0);
    assign ledSingle = !ledNone && !ledMulti;
    assign rdNext    = rdPtr_q + ADDR_WIDTH'(1);

    // A failure only fires once per multi-LED episode; LEDs must go dark to re-arm.
    assign failEvt    = ledMulti && armed_q;
    assign continuing = (onCnt_q != '0) && (ledColor == color_q);

    always_comb begin
        case (leds)
            4'b0010: ledColor = COLOR_CODEFY_W'(1);
            4'b0100: ledColor = COLOR_CODEFY_W'(2);
            4'b1000: ledColor = COLOR_CODEFY_W'(3);
            default: ledColor = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        onCnt_d   = '0;
        idleCnt_d = '0;
        color_d   = color_q;
        tmr_d     = tmr_q;
        armed_d   = ledNone ? 1'b1 : (failEvt ? 1'b0 : armed_q);
        button_d  = button_q;
        press_d   = press_q;
        ovf_d     = ovf_q;
        fail_d    = 1'b0;
        memWe     = 1'b0;

        if (!enable) begin
            state_d  = S_LISTEN;
            wrPtr_d  = '0;
            rdPtr_d  = '0;
            count_d  = '0;
            tmr_d    = '0;
            button_d = '0;
            press_d  = 1'b0;
            ovf_d    = 1'b0;
        end else if (failEvt) begin
            state_d = S_LISTEN;
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
            tmr_d   = '0;
            press_d = 1'b0;
            fail_d  = 1'b1;
        end else begin
            case (state_q)
                S_LISTEN: begin
                    if (ledSingle) begin
                        color_d = ledColor;
                        if (continuing)
                            onCnt_d = (onCnt_q == ON_MAX) ? onCnt_q : onCnt_q + TW'(1);
                        else
                            onCnt_d = TW'(1);
                        // Capture on the cycle the count first reaches the threshold.
                        if (armed_q && onCnt_d == ON_MAX && !(continuing && onCnt_q == ON_MAX)) begin
                            if (count_q == FULL) begin
                                ovf_d = 1'b1;
                            end else begin
                                memWe   = 1'b1;
                                wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
                                count_d = count_q + CW'(1);
                            end
                        end
                    end
                    if (ledNone && count_q != '0) begin
                        if (idleCnt_q == IDLE_LAST) begin
                            state_d  = S_PRESS;
                            rdPtr_d  = '0;
                            tmr_d    = '0;
                            press_d  = 1'b1;
                            button_d = mem_q[0];
                        end else begin
                            idleCnt_d = idleCnt_q + TW'(1);
                        end
                    end
                end
                S_PRESS: begin
                    if (tmr_q == PRESS_LAST) begin
                        state_d = S_GAP;
                        tmr_d   = '0;
                        press_d = 1'b0;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                S_GAP: begin
                    if (tmr_q == GAP_LAST) begin
                        tmr_d = '0;
                        if (CW'(rdPtr_q) + CW'(1) == count_q) begin
                            state_d = S_LISTEN;
                            wrPtr_d = '0;
                            rdPtr_d = '0;
                            count_d = '0;
                        end else begin
                            state_d  = S_PRESS;
                            rdPtr_d  = rdNext;
                            press_d  = 1'b1;
                            button_d = mem_q[rdNext];
                        end
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
                default: state_d = S_LISTEN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (memWe)
            mem_q[wrPtr_q] <= ledColor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_LISTEN;
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            onCnt_q   <= '0;
            idleCnt_q <= '0;
            color_q   <= '0;
            tmr_q     <= '0;
            armed_q   <= 1'b1;
            button_q  <= '0;
            press_q   <= 1'b0;
            ovf_q     <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            onCnt_q   <= onCnt_d;
            idleCnt_q <= idleCnt_d;
            color_q   <= color_d;
            tmr_q     <= tmr_d;
            armed_q   <= armed_d;
            button_q  <= button_d;
            press_q   <= press_d;
            ovf_q     <= ovf_d;
            fail_q    <= fail_d;
        end
    end

    assign player_button  = button_q;
    assign player_press   = press_q;
    assign busy           = (state_q != S_LISTEN);
    assign overflow       = ovf_q;
    assign fail_seen      = fail_q;
    assign captured_count = count_q;

endmodule

// File: tb/tb_auto_player.sv
// Testbench for auto_player: drives LED pulse patterns and checks captures and
// replayed presses against a transaction-level model of the recorded colours.
module tb_auto_player;
    localparam int MIN_ON = 4;
    localparam int IDLE   = 64;
    localparam int PRESS  = 8;
    localparam int GAP    = 8;
    localparam int DEPTH  = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       led_red, led_green, led_blue, led_yellow;
    logic [1:0] player_button;
    logic       player_press, busy, overflow, fail_seen;
    logic [5:0] captured_count;

    int compareCnt  = 0;
    int mismatchCnt = 0;

    int modelQ[$];
    int modelIdle  = 0;
    bit modelOvf   = 1'b0;
    bit modelArmed = 1'b1;

    auto_player dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .led_red        (led_red),
        .led_green      (led_green),
        .led_blue       (led_blue),
        .led_yellow     (led_yellow),
        .player_button  (player_button),
        .player_press   (player_press),
        .busy           (busy),
        .overflow       (overflow),
        .fail_seen      (fail_seen),
        .captured_count (captured_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCnt++;
        if (observed !== expected) begin
            mismatchCnt++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Colour code 0..3 lights one LED, -1 is all off, 4 lights all four.
    task automatic setLeds(input int c);
        led_red    = (c == 0) || (c == 4);
        led_green  = (c == 1) || (c == 4);
        led_blue   = (c == 2) || (c == 4);
        led_yellow = (c == 3) || (c == 4);
    endtask

    task automatic applyStimulus(input int c, input int onCycles, input int offCycles);
        for (int k = 1; k <= onCycles; k++) begin
            setLeds(c);
            step();
            modelIdle = 0;
            if (k == MIN_ON && modelArmed) begin
                if (modelQ.size() < DEPTH) modelQ.push_back(c);
                else modelOvf = 1'b1;
            end
            checkOutput("capCount", int'(captured_count), modelQ.size());
        end
        setLeds(-1);
        for (int k = 0; k < offCycles; k++) begin
            step();
            modelArmed = 1'b1;
            if (modelQ.size() > 0) modelIdle++;
        end
    endtask

    task automatic quietCheck(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            step();
            if (player_press === 1'b1 || busy === 1'b1) seen++;
        end
        checkOutput(tag, seen, 0);
    endtask

    task automatic replayCheck(input int failAt);
        int n, waitCnt, len, gap, busyCnt;
        n       = modelQ.size();
        busyCnt = 0;
        waitCnt = 0;
        setLeds(-1);
        while (player_press !== 1'b1 && waitCnt < 300) begin
            step();
            waitCnt++;
        end
        checkOutput("idleLen", waitCnt, IDLE - modelIdle);
        for (int i = 0; i < n; i++) begin
            if (i == failAt) begin
                setLeds(4);
                step();
                checkOutput("failPulse", int'(fail_seen), 1);
                checkOutput("failPress", int'(player_press), 0);
                checkOutput("failCount", int'(captured_count), 0);
                checkOutput("failBusy", int'(busy), 0);
                step();
                checkOutput("failOnce", int'(fail_seen), 0);
                setLeds(-1);
                step();
                modelQ.delete();
                modelIdle  = 0;
                modelArmed = 1'b1;
                return;
            end
            checkOutput("pressBtn", int'(player_button), modelQ[i]);
            len = 0;
            while (player_press === 1'b1 && len < 100) begin
                if (busy === 1'b1) busyCnt++;
                len++;
                step();
            end
            checkOutput("pressLen", len, PRESS);
            checkOutput("holdBtn", int'(player_button), modelQ[i]);
            gap = 0;
            while (player_press === 1'b0 && busy === 1'b1 && gap < 100) begin
                busyCnt++;
                gap++;
                step();
            end
            checkOutput("gapLen", gap, GAP);
        end
        checkOutput("busyTotal", busyCnt, n * (PRESS + GAP));
        checkOutput("cntAfter", int'(captured_count), 0);
        checkOutput("busyAfter", int'(busy), 0);
        modelQ.delete();
        modelIdle = 0;
        quietCheck("noExtraPress", 20);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, waitCnt;
        rst_n  = 1'b0;
        enable = 1'b1;
        setLeds(-1);
        repeat (3) step();
        checkOutput("rstPress", int'(player_press), 0);
        checkOutput("rstButton", int'(player_button), 0);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstOvf", int'(overflow), 0);
        checkOutput("rstFail", int'(fail_seen), 0);
        checkOutput("rstCount", int'(captured_count), 0);
        rst_n = 1'b1;
        step();

        $display("[TB] single red pulse");
        applyStimulus(0, 10, 1);
        replayCheck(-1);

        $display("[TB] green, blue, yellow, red");
        applyStimulus(1, 10, 10);
        applyStimulus(2, 10, 10);
        applyStimulus(3, 10, 10);
        applyStimulus(0, 10, 10);
        replayCheck(-1);

        $display("[TB] short glitch");
        applyStimulus(2, 3, 5);
        quietCheck("glitchNoReplay", 150);

        $display("[TB] random sequences");
        for (int r = 0; r < 2; r++) begin
            n = $urandom_range(12, 5);
            for (int p = 0; p < n; p++) begin
                if ($urandom_range(3, 0) == 0)
                    applyStimulus($urandom_range(3, 0), $urandom_range(MIN_ON - 1, 1), $urandom_range(12, 1));
                applyStimulus($urandom_range(3, 0), $urandom_range(MIN_ON + 8, MIN_ON), $urandom_range(12, 1));
            end
            replayCheck(-1);
        end

        $display("[TB] overflow");
        for (int p = 0; p < DEPTH + 1; p++)
            applyStimulus($urandom_range(3, 0), 5, 2);
        checkOutput("ovfCount", int'(captured_count), DEPTH);
        checkOutput("ovfSet", int'(overflow), int'(modelOvf));
        replayCheck(-1);
        checkOutput("ovfSticky", int'(overflow), 1);

        $display("[TB] failure during third press");
        for (int p = 0; p < 4; p++)
            applyStimulus($urandom_range(3, 0), 6, 3);
        replayCheck(2);
        checkOutput("failListenCnt", int'(captured_count), 0);
        quietCheck("failNoReplay", 100);
        applyStimulus(3, 6, 2);
        replayCheck(-1);

        $display("[TB] enable low mid-capture");
        applyStimulus(1, 8, 3);
        setLeds(2);
        step();
        step();
        enable = 1'b0;
        step();
        checkOutput("enCount", int'(captured_count), 0);
        checkOutput("enOvf", int'(overflow), 0);
        checkOutput("enBusy", int'(busy), 0);
        checkOutput("enPress", int'(player_press), 0);
        setLeds(3);
        repeat (6) step();
        checkOutput("enNoCapture", int'(captured_count), 0);
        setLeds(-1);
        step();
        enable = 1'b1;
        modelQ.delete();
        modelIdle = 0;
        quietCheck("enNoReplay", 150);
        applyStimulus(0, 5, 1);
        replayCheck(-1);

        $display("[TB] reset during replay");
        applyStimulus(2, 6, 1);
        applyStimulus(1, 6, 1);
        waitCnt = 0;
        while (player_press !== 1'b1 && waitCnt < 300) begin
            step();
            waitCnt++;
        end
        checkOutput("rstMidPress", int'(player_press), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("asyncPress", int'(player_press), 0);
        checkOutput("asyncButton", int'(player_button), 0);
        checkOutput("asyncBusy", int'(busy), 0);
        checkOutput("asyncCount", int'(captured_count), 0);
        #2;
        rst_n = 1'b1;
        modelQ.delete();
        modelIdle = 0;
        quietCheck("rstNoReplay", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
        $finish;
    end

endmodule

// File: doc/auto_player.md
Name: auto_player

Overview:
- Automatic responder for the Genius game; plays the player's side of the LED/button interface.
- Watches the four colour LEDs driven by the game core and records each displayed colour in order.
- When the display phase goes quiet, replays the recorded sequence as colour-coded button presses on the game's player_button input.
- Used for self-play demo mode and as a closed-loop stimulus agent in game-level regression.

Parameters:
- COLOR_CODEFY_W, 2, colour code width; fixed encoding red=0, green=1, blue=2, yellow=3.
- ADDR_WIDTH, 5, buffer address width; DEPTH = 2**ADDR_WIDTH = 32 entries.
- MIN_ON_CYCLES, 4, consecutive cycles a single LED must be on before it is captured.
- IDLE_CYCLES, 64, all-LEDs-off cycles after the last capture that end the display phase.
- PRESS_CYCLES, 8, cycles player_press is held high per replayed item.
- GAP_CYCLES, 8, low cycles between replayed presses.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; asynchronous, active-low.
- enable  input  1  auto-play enable; when low, the block is held flushed in LISTEN.
- led_red, led_green, led_blue, led_yellow  input  1 each  game LEDs, synchronous to clk.
- player_button  output  COLOR_CODEFY_W  colour code of the current press.
- player_press  output  1  press strobe, high while the button is held.
- busy  output  1  high in REPLAY_PRESS and REPLAY_GAP.
- overflow  output  1  sticky flag; set when a capture is attempted with the buffer full.
- fail_seen  output  1  one-cycle pulse when a failure indication is detected.
- captured_count  output  ADDR_WIDTH+1  number of entries held, 0..32.

Behaviour:
- Reset (async, rst_n low):
  - State goes to LISTEN.
  - All outputs become 0; buffer count, write/read pointers, and the on/idle/press/gap timers clear.
- LED decode: one-hot LED pattern maps to a colour code. More than one LED on is treated as the failure indication (all_leds).
- LISTEN (enable=1):
  - on_cnt counts consecutive cycles with the same single LED on, saturating at MIN_ON_CYCLES.
  - A change of colour or LEDs off clears on_cnt.
  - When on_cnt reaches MIN_ON_CYCLES, the colour is written at wr_ptr and count increments. This happens once per pulse; no re-capture until the LED goes off.
  - Pulses shorter than MIN_ON_CYCLES are ignored.
  - Capture with count==32: entry dropped, overflow set. overflow clears only on reset or enable low.
  - idle_cnt counts all-off cycles while count>0; any LED on clears it.
  - When idle_cnt reaches IDLE_CYCLES, go to REPLAY_PRESS with rd_ptr=0.
  - With count==0, LISTEN never times out.
- REPLAY_PRESS:
  - player_button = buf[rd_ptr] and player_press=1, both registered.
  - Both appear the cycle after entry and last exactly PRESS_CYCLES cycles, then go to REPLAY_GAP.
- REPLAY_GAP:
  - player_press=0 and player_button holds its value for GAP_CYCLES cycles.
  - Then rd_ptr increments. If rd_ptr==count, flush the buffer (count=0, pointers 0) and go to LISTEN; otherwise go to REPLAY_PRESS.
- LED inputs during replay are ignored for capture; the game echoes presses on the LEDs.
- Failure indication (more than one LED on) in any state:
  - Pulse fail_seen for one cycle.
  - Flush the buffer, drop player_press to 0 the next cycle, and go to LISTEN.
  - Capture resumes only after all LEDs have been off for one cycle.
- enable low (any state): next cycle state=LISTEN, buffer flushed, player_press=0, busy=0, overflow=0. Nothing is captured while low.
- Each round the game redisplays the full sequence, so the buffer is rebuilt from empty every round.
- Width rules:
  - Pointers are ADDR_WIDTH bits and wrap naturally.
  - count is ADDR_WIDTH+1 bits and never exceeds 32.
  - Timers are sized by $clog2 of the largest parameter + 1 and saturate.

Test Plan:
- Single pulse: red on 10 cycles, then off -> captured_count=1 at cycle 4 of the pulse. After 64 idle cycles, player_button=0 and player_press=1 for 8 cycles, then 8 gap cycles, then captured_count=0 and busy=0.
- Sequence green, blue, yellow, red (10 on / 10 off each) -> replayed codes 1, 2, 3, 0 in order, each with an 8-cycle press and an 8-cycle gap; busy high for 64 cycles.
- Glitch: blue on 3 cycles -> no capture, captured_count stays 0, no replay ever starts.
- Overflow: 33 valid pulses -> captured_count=32, overflow=1, and the replay emits exactly 32 presses matching the first 32 colours.
- Failure: all four LEDs on during the third replayed press -> fail_seen pulses once, player_press=0 next cycle, captured_count=0, state LISTEN.
- Reset/enable mid-operation: rst_n low during REPLAY_PRESS -> outputs 0 immediately (async). Separately, enable low mid-capture -> buffer flushed, overflow cleared, and no replay after re-enable until new pulses arrive.
